// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one at a time, waiting for each stage's ready ack and a settle delay.
// Lost acks or ack timeouts park the block in FAULT until a software restart.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned CNTR_WIDTH  = 16,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned ACK_TIMEOUT = 50000,
    parameter int unsigned STAGE_DELAY = 500
) (
    input  logic                  clk,
    input  logic                  global_reset,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  fault,
    output logic [2:0]            fault_stage
);

    localparam int unsigned IDX_W = 3;

    localparam logic [CNTR_WIDTH-1:0] HOLD_LAST   = CNTR_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] ACK_LAST    = CNTR_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [CNTR_WIDTH-1:0] SETTLE_LAST = CNTR_WIDTH'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        RELEASE  = 3'd1,
        WAIT_ACK = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                    all_ready_q, all_ready_d;
    logic                    fault_q, fault_d;
    logic [IDX_W-1:0]        fault_stage_q, fault_stage_d;

    logic                    cur_ack;
    logic                    lost_any;
    logic [IDX_W-1:0]        lost_idx;

    // Ack of the stage being released, and lowest released stage whose ack is low
    always_comb begin
        cur_ack  = 1'b0;
        lost_any = 1'b0;
        lost_idx = '0;
        for (int j = int'(NUM_STAGES) - 1; j >= 0; j--) begin
            if (IDX_W'(j) == idx_q) begin
                cur_ack = stage_ack[j];
            end
            if (!stage_ack[j] &&
                ((state_q == DONE) ||
                 (((state_q == WAIT_ACK) || (state_q == SETTLE)) && (IDX_W'(j) < idx_q)))) begin
                lost_any = 1'b1;
                lost_idx = IDX_W'(j);
            end
        end
    end

    // Next-state, counter, stage index and registered output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_rst_d   = stage_rst_q;
        fault_stage_d = fault_stage_q;

        if (sw_reset_req) begin
            state_d     = HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            stage_rst_d = '1;
        end else begin
            case (state_q)
                HOLD: begin
                    stage_rst_d = '1;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTR_WIDTH'(1);
                    end
                end
                RELEASE: begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                    // Stages up to and including idx are out of reset
                    for (int j = 0; j < int'(NUM_STAGES); j++) begin
                        stage_rst_d[j] = (IDX_W'(j) > idx_q);
                    end
                end
                WAIT_ACK: begin
                    if (lost_any) begin
                        state_d       = FAULT;
                        cnt_d         = '0;
                        stage_rst_d   = '1;
                        fault_stage_d = lost_idx;
                    end else if (cur_ack) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == ACK_LAST) begin
                        state_d       = FAULT;
                        cnt_d         = '0;
                        stage_rst_d   = '1;
                        fault_stage_d = idx_q;
                    end else begin
                        cnt_d = cnt_q + CNTR_WIDTH'(1);
                    end
                end
                SETTLE: begin
                    if (lost_any) begin
                        state_d       = FAULT;
                        cnt_d         = '0;
                        stage_rst_d   = '1;
                        fault_stage_d = lost_idx;
                    end else if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d     = DONE;
                            stage_rst_d = '0;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNTR_WIDTH'(1);
                    end
                end
                DONE: begin
                    stage_rst_d = '0;
                    if (lost_any) begin
                        state_d       = FAULT;
                        cnt_d         = '0;
                        stage_rst_d   = '1;
                        fault_stage_d = lost_idx;
                    end
                end
                FAULT: begin
                    stage_rst_d = '1;
                end
                default: begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                end
            endcase
        end

        all_ready_d = (state_d == DONE);
        fault_d     = (state_d == FAULT);
    end

    // State and output registers with synchronous global reset
    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q       <= HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            stage_rst_q   <= '1;
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_rst_q   <= stage_rst_d;
            all_ready_q   <= all_ready_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign stage_rst   = stage_rst_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

endmodule
